// File: rtl/btree_pkg.sv
// Shared BTree switch definitions: tree geometry, packet widths, address helper.
package btree_pkg;
   localparam int NUMPE      = 4;
   localparam int DataWidth  = 32;
   localparam int AddrWidth  = $clog2(NUMPE);
   localparam int TotalWidth = DataWidth + AddrWidth;
   localparam int NUM_PORTS  = 2;

   // Destination address lives in the packet MSBs.
   function automatic logic [AddrWidth-1:0] addr_of(input logic [TotalWidth-1:0] pkt);
      return pkt[TotalWidth-1 -: AddrWidth];
   endfunction
endpackage

// File: rtl/btree_rr_arb2.sv
// Two-requester round-robin arbiter; the last winner loses the next tie.
module btree_rr_arb2 (
   input  logic       clk100,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);
   logic prio;

   always_comb begin
      gnt = req;
      if (&req) gnt = prio ? 2'b10 : 2'b01;
   end

   // advance qualifies gnt as an actual transfer; loser of this grant gets priority.
   always_ff @(posedge clk100) begin
      if (rst)          prio <= 1'b0;
      else if (advance) prio <= gnt[0];
   end
endmodule

// File: rtl/btree_uplink_arbiter.sv
// 2:1 uplink merge for a BTree switch node: RR grant, one-entry output register, per-port counters.
module btree_uplink_arbiter
   import btree_pkg::*;
#(
   parameter int DataWidth  = btree_pkg::DataWidth,
   parameter int AddrWidth  = btree_pkg::AddrWidth,
   parameter int TotalWidth = DataWidth + AddrWidth,
   parameter int CntWidth   = 16
) (
   input  logic                  clk100,
   input  logic                  rst,
   input  logic [TotalWidth-1:0] i_data0,
   input  logic                  i_data_valid0,
   output logic                  o_data_ready0,
   input  logic [TotalWidth-1:0] i_data1,
   input  logic                  i_data_valid1,
   output logic                  o_data_ready1,
   output logic [TotalWidth-1:0] o_data,
   output logic                  o_data_valid,
   input  logic                  i_data_ready,
   output logic [CntWidth-1:0]   o_pkt_count0,
   output logic [CntWidth-1:0]   o_pkt_count1
);
   logic [NUM_PORTS-1:0]                 req, gnt, acc;
   logic [NUM_PORTS-1:0][TotalWidth-1:0] din;
   logic [NUM_PORTS-1:0][CntWidth-1:0]   cnt;
   logic                                 can_accept, advance;

   assign req        = {i_data_valid1, i_data_valid0};
   assign din        = {i_data1, i_data0};
   assign can_accept = !o_data_valid || i_data_ready;
   // rst gating keeps readies low during reset so no child believes it was taken.
   assign acc        = (can_accept && !rst) ? gnt : '0;
   assign advance    = |acc;

   assign o_data_ready0 = acc[0];
   assign o_data_ready1 = acc[1];
   assign o_pkt_count0  = cnt[0];
   assign o_pkt_count1  = cnt[1];

   btree_rr_arb2 u_arb (
      .clk100  (clk100),
      .rst     (rst),
      .req     (req),
      .advance (advance),
      .gnt     (gnt)
   );

   always_ff @(posedge clk100) begin
      if (rst) begin
         o_data       <= '0;
         o_data_valid <= 1'b0;
      end else if (advance) begin
         o_data       <= acc[1] ? din[1] : din[0];
         o_data_valid <= 1'b1;
      end else if (i_data_ready) begin
         o_data_valid <= 1'b0;
      end
   end

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_cnt
      always_ff @(posedge clk100) begin
         if (rst)         cnt[p] <= '0;
         else if (acc[p]) cnt[p] <= cnt[p] + 1'b1;
      end
   end
endmodule

// File: tb/tb_btree_uplink_arbiter.sv
// Directed table plus hand sequences for the BTree uplink arbiter.
module tb_btree_uplink_arbiter;
   localparam int TW = 34;

   typedef struct {
      logic [3:0]    in;   // {rst, v0, v1, rdy}
      logic [TW-1:0] d0;
      logic [TW-1:0] d1;
      logic [2:0]    ex;   // {ready0, ready1, o_data_valid}
      logic [TW-1:0] ed;
      logic [15:0]   c0;
      logic [15:0]   c1;
   } vec_t;

   logic          clk100 = 1'b0;
   logic          rst = 1'b1;
   logic [TW-1:0] d0 = '0, d1 = '0;
   logic          v0 = 1'b0, v1 = 1'b0, rdy = 1'b0;
   logic          r0, r1, ov;
   logic [TW-1:0] od;
   logic [15:0]   c0, c1;

   logic          w_rst = 1'b1, w_v1 = 1'b0;
   logic          w_r0, w_r1, w_ov;
   logic [TW-1:0] w_od;
   logic [3:0]    w_c0, w_c1;

   int applied = 0;
   int miscompares = 0;

   always #5 clk100 = ~clk100;

   btree_uplink_arbiter dut (
      .clk100(clk100), .rst(rst),
      .i_data0(d0), .i_data_valid0(v0), .o_data_ready0(r0),
      .i_data1(d1), .i_data_valid1(v1), .o_data_ready1(r1),
      .o_data(od), .o_data_valid(ov), .i_data_ready(rdy),
      .o_pkt_count0(c0), .o_pkt_count1(c1)
   );

   btree_uplink_arbiter #(.CntWidth(4)) dut_w (
      .clk100(clk100), .rst(w_rst),
      .i_data0('0), .i_data_valid0(1'b0), .o_data_ready0(w_r0),
      .i_data1(34'h2_0000_0000), .i_data_valid1(w_v1), .o_data_ready1(w_r1),
      .o_data(w_od), .o_data_valid(w_ov), .i_data_ready(1'b1),
      .o_pkt_count0(w_c0), .o_pkt_count1(w_c1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic after_edge();
      @(posedge clk100);
      #1;
   endtask

   vec_t vt[15];

   initial begin
      vt[0]  = '{4'b1111, 34'h0,          34'h0,          3'b000, 34'h0,          16'd0, 16'd0};
      vt[1]  = '{4'b0001, 34'h0,          34'h0,          3'b000, 34'h0,          16'd0, 16'd0};
      vt[2]  = '{4'b0101, 34'h1_DEADBEEF, 34'h0,          3'b101, 34'h1_DEADBEEF, 16'd1, 16'd0};
      vt[3]  = '{4'b0001, 34'h0,          34'h0,          3'b000, 34'h1_DEADBEEF, 16'd1, 16'd0};
      vt[4]  = '{4'b0011, 34'h0,          34'h2_00000011, 3'b011, 34'h2_00000011, 16'd1, 16'd1};
      vt[5]  = '{4'b0111, 34'h0_AAAA0000, 34'h3_BBBB0000, 3'b101, 34'h0_AAAA0000, 16'd2, 16'd1};
      vt[6]  = '{4'b0111, 34'h0_AAAA0000, 34'h3_BBBB0000, 3'b011, 34'h3_BBBB0000, 16'd2, 16'd2};
      vt[7]  = '{4'b0110, 34'h0_AAAA0000, 34'h3_BBBB0000, 3'b001, 34'h3_BBBB0000, 16'd2, 16'd2};
      vt[8]  = '{4'b0110, 34'h0_AAAA0000, 34'h3_BBBB0000, 3'b001, 34'h3_BBBB0000, 16'd2, 16'd2};
      vt[9]  = '{4'b0111, 34'h0_AAAA0000, 34'h3_BBBB0000, 3'b101, 34'h0_AAAA0000, 16'd3, 16'd2};
      vt[10] = '{4'b0100, 34'h0_CCCC0000, 34'h0,          3'b001, 34'h0_AAAA0000, 16'd3, 16'd2};
      vt[11] = '{4'b0001, 34'h0,          34'h0,          3'b000, 34'h0_AAAA0000, 16'd3, 16'd2};
      vt[12] = '{4'b0010, 34'h0,          34'h1_12345678, 3'b011, 34'h1_12345678, 16'd3, 16'd3};
      vt[13] = '{4'b1100, 34'h0_55555555, 34'h0,          3'b000, 34'h0,          16'd0, 16'd0};
      vt[14] = '{4'b0111, 34'h0_00000001, 34'h2_00000002, 3'b101, 34'h0_00000001, 16'd1, 16'd0};

      for (int i = 0; i < 15; i++) begin
         {rst, v0, v1, rdy} = vt[i].in;
         d0 = vt[i].d0;
         d1 = vt[i].d1;
         @(negedge clk100);
         chk($sformatf("v%0d ready", i), {62'd0, r0, r1}, {62'd0, vt[i].ex[2:1]});
         after_edge();
         chk($sformatf("v%0d valid", i), {63'd0, ov}, {63'd0, vt[i].ex[0]});
         chk($sformatf("v%0d data", i), {30'd0, od}, {30'd0, vt[i].ed});
         chk($sformatf("v%0d counts", i), {32'd0, c0, c1}, {32'd0, vt[i].c0, vt[i].c1});
      end

      // Sustained tie straight out of reset: strict 0,1,0,1 alternation at full rate.
      rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rdy = 1'b1;
      after_edge();
      rst = 1'b0; v0 = 1'b1; v1 = 1'b1;
      d0 = 34'h0_000000F0; d1 = 34'h1_000000F1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk100);
         chk($sformatf("tie%0d ready", k), {62'd0, r0, r1}, (k % 2 == 0) ? 64'd2 : 64'd1);
         after_edge();
         chk($sformatf("tie%0d data", k), {29'd0, ov, od}, (k % 2 == 0) ? {29'd1, 34'h0_000000F0} : {29'd1, 34'h1_000000F1});
      end
      chk("tie counts", {32'd0, c0, c1}, {32'd0, 16'd4, 16'd4});

      // Backpressure for 5 cycles, then drain and accept on the same edge.
      v1 = 1'b0; rdy = 1'b0; d0 = 34'h0_77777777;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk100);
         chk($sformatf("bp%0d ready", k), {62'd0, r0, r1}, 64'd0);
         after_edge();
         chk($sformatf("bp%0d hold", k), {29'd0, ov, od}, {29'd1, 34'h1_000000F1});
      end
      rdy = 1'b1;
      @(negedge clk100);
      chk("bp resume ready", {62'd0, r0, r1}, 64'd2);
      after_edge();
      chk("bp resume data", {29'd0, ov, od}, {29'd1, 34'h0_77777777});
      chk("bp counts", {32'd0, c0, c1}, {32'd0, 16'd5, 16'd4});
      v0 = 1'b0;

      // Counter wrap on a 4-bit instance: 16 packets -> 0, 17 -> 1.
      after_edge();
      w_rst = 1'b0; w_v1 = 1'b1;
      for (int k = 0; k < 16; k++) after_edge();
      chk("wrap16", {56'd0, w_c0, w_c1}, 64'd0);
      after_edge();
      w_v1 = 1'b0;
      chk("wrap17", {56'd0, w_c0, w_c1}, 64'd1);
      chk("wrap data", {29'd0, w_ov, w_od}, {29'd1, 34'h2_0000_0000});

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end
endmodule
